inst_fetch_resp: RTL and testbench

INST_FETCH_RESP -- requirements
Module: inst_fetch_resp

---
 rtl/inst_fetch_resp_pkg.sv | 23 ++
 rtl/inst_fetch_resp.sv | 210 +++++++++++++++++++++
 tb/tb_inst_fetch_resp.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_resp_pkg.sv
// ----------------------------------------------------------------------------
// inst_fetch_resp_pkg
// Shared constants and types for the instruction fetch response block:
//   INST_ADDR_W / INST_W : instruction address and instruction bus widths
//   NOP_INST             : instruction injected for misaligned/timed-out fetches
//   TIMEOUT_LIMIT        : timer value at which a stuck bus transfer is abandoned
//   state_e              : fetch state machine encoding
// ----------------------------------------------------------------------------
package inst_fetch_resp_pkg;

    localparam int INST_ADDR_W = 32;
    localparam int INST_W      = 32;

    localparam logic [INST_W-1:0] NOP_INST      = 32'h0000_0013;   // addi x0, x0, 0
    localparam logic [7:0]        TIMEOUT_LIMIT = 8'd255;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/inst_fetch_resp.sv
// ----------------------------------------------------------------------------
// inst_fetch_resp
// Turns fetch-stage requests (ce_i/pc_i) into single-word memory bus reads and
// presents the returned instruction to decode. The last fetched address is
// remembered so an unchanged pc_i does not re-fetch. Misaligned addresses are
// answered locally with a NOP. A flush during a transfer lets the transfer
// finish on the bus (DRAIN) but throws its data away.
//
// Ports:
//   clk_i           : clock, rising edge
//   n_rst_i         : synchronous active-low reset
//   ce_i            : fetch enable
//   pc_i            : fetch address
//   flush_i         : discard any in-flight fetch
//   mem_req_o       : bus request (held until ack)
//   mem_addr_o      : bus word address
//   mem_ack_i       : bus read-data valid
//   mem_rdata_i     : bus read data
//   inst_o          : instruction to decode
//   inst_valid_o    : inst_o belongs to the held address
//   inst_misalign_o : held address is not word aligned
//   inst_timeout_o  : fetch was abandoned by the timeout
//   stall_req_o     : stall request to the pipeline controller
//
// Build option:
//   INST_FETCH_TIMEOUT_EN : adds an 8-bit watchdog that abandons a transfer
//                           after 256 cycles without ack. Without it the block
//                           waits forever and inst_timeout_o is constant 0.
// ----------------------------------------------------------------------------
module inst_fetch_resp
    import inst_fetch_resp_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   n_rst_i,
    input  logic                   ce_i,
    input  logic [INST_ADDR_W-1:0] pc_i,
    input  logic                   flush_i,
    output logic                   mem_req_o,
    output logic [INST_ADDR_W-1:0] mem_addr_o,
    input  logic                   mem_ack_i,
    input  logic [INST_W-1:0]      mem_rdata_i,
    output logic [INST_W-1:0]      inst_o,
    output logic                   inst_valid_o,
    output logic                   inst_misalign_o,
    output logic                   inst_timeout_o,
    output logic                   stall_req_o
);

    state_e                 state_reg, state_next;
    logic [INST_ADDR_W-1:0] held_pc_reg, held_pc_next;
    logic                   held_vld_reg, held_vld_next;
    logic                   mem_req_reg, mem_req_next;
    logic [INST_ADDR_W-1:0] mem_addr_reg, mem_addr_next;
    logic [INST_W-1:0]      inst_reg, inst_next;
    logic                   inst_valid_reg, inst_valid_next;
    logic                   misalign_reg, misalign_next;
`ifdef INST_FETCH_TIMEOUT_EN
    logic [7:0]             timer_reg, timer_next;
    logic                   timeout_reg, timeout_next;
`endif

    // A fetch is needed when enabled and the held instruction does not match pc_i.
    logic need;
    assign need = ce_i && (!held_vld_reg || (pc_i != held_pc_reg));

    always_ff @(posedge clk_i) begin
        if (!n_rst_i) begin
            state_reg      <= ST_IDLE;
            held_pc_reg    <= '0;
            held_vld_reg   <= 1'b0;
            mem_req_reg    <= 1'b0;
            mem_addr_reg   <= '0;
            inst_reg       <= NOP_INST;
            inst_valid_reg <= 1'b0;
            misalign_reg   <= 1'b0;
`ifdef INST_FETCH_TIMEOUT_EN
            timer_reg      <= '0;
            timeout_reg    <= 1'b0;
`endif
        end else begin
            state_reg      <= state_next;
            held_pc_reg    <= held_pc_next;
            held_vld_reg   <= held_vld_next;
            mem_req_reg    <= mem_req_next;
            mem_addr_reg   <= mem_addr_next;
            inst_reg       <= inst_next;
            inst_valid_reg <= inst_valid_next;
            misalign_reg   <= misalign_next;
`ifdef INST_FETCH_TIMEOUT_EN
            timer_reg      <= timer_next;
            timeout_reg    <= timeout_next;
`endif
        end
    end

    always_comb begin
        state_next      = state_reg;
        held_pc_next    = held_pc_reg;
        held_vld_next   = held_vld_reg;
        mem_req_next    = mem_req_reg;
        mem_addr_next   = mem_addr_reg;
        inst_next       = inst_reg;
        inst_valid_next = inst_valid_reg;
        misalign_next   = misalign_reg;
`ifdef INST_FETCH_TIMEOUT_EN
        timer_next      = timer_reg;
        timeout_next    = timeout_reg;
`endif

        case (state_reg)
            ST_IDLE: begin
                if (flush_i) begin
                    held_vld_next   = 1'b0;
                    inst_valid_next = 1'b0;
                end else if (need) begin
                    held_pc_next = pc_i;
`ifdef INST_FETCH_TIMEOUT_EN
                    timeout_next = 1'b0;
`endif
                    if (pc_i[1:0] != 2'b00) begin
                        // Misaligned: answer locally, never touch the bus.
                        held_vld_next   = 1'b1;
                        inst_next       = NOP_INST;
                        inst_valid_next = 1'b1;
                        misalign_next   = 1'b1;
                    end else begin
                        state_next      = ST_BUSY;
                        mem_req_next    = 1'b1;
                        mem_addr_next   = pc_i;
                        held_vld_next   = 1'b0;
                        inst_valid_next = 1'b0;
                        misalign_next   = 1'b0;
`ifdef INST_FETCH_TIMEOUT_EN
                        timer_next      = '0;
`endif
                    end
                end
            end

            ST_BUSY: begin
                if (mem_ack_i) begin
                    state_next   = ST_IDLE;
                    mem_req_next = 1'b0;
                    if (flush_i) begin
                        // Data arrived together with the flush: it is stale.
                        held_vld_next   = 1'b0;
                        inst_valid_next = 1'b0;
                    end else begin
                        inst_next       = mem_rdata_i;
                        inst_valid_next = 1'b1;
                        held_vld_next   = 1'b1;
                    end
                end else if (flush_i) begin
                    // The bus transfer must still complete; wait for it in DRAIN.
                    state_next      = ST_DRAIN;
                    held_vld_next   = 1'b0;
                    inst_valid_next = 1'b0;
`ifdef INST_FETCH_TIMEOUT_EN
                    timer_next      = '0;
                end else if (timer_reg == TIMEOUT_LIMIT) begin
                    state_next      = ST_IDLE;
                    mem_req_next    = 1'b0;
                    inst_next       = NOP_INST;
                    inst_valid_next = 1'b1;
                    held_vld_next   = 1'b1;
                    timeout_next    = 1'b1;
                end else begin
                    timer_next = timer_reg + 8'd1;
`endif
                end
            end

            ST_DRAIN: begin
                if (mem_ack_i) begin
                    state_next   = ST_IDLE;
                    mem_req_next = 1'b0;
`ifdef INST_FETCH_TIMEOUT_EN
                end else if (timer_reg == TIMEOUT_LIMIT) begin
                    // The flushed fetch is already dead; abandon without reporting.
                    state_next      = ST_IDLE;
                    mem_req_next    = 1'b0;
                    inst_valid_next = 1'b0;
                    held_vld_next   = 1'b0;
                    timeout_next    = 1'b0;
                end else begin
                    timer_next = timer_reg + 8'd1;
`endif
                end
            end

            default: begin
                state_next   = ST_IDLE;
                mem_req_next = 1'b0;
            end
        endcase
    end

    assign mem_req_o       = mem_req_reg;
    assign mem_addr_o      = mem_addr_reg;
    assign inst_o          = inst_reg;
    assign inst_valid_o    = inst_valid_reg;
    assign inst_misalign_o = misalign_reg;
`ifdef INST_FETCH_TIMEOUT_EN
    assign inst_timeout_o  = timeout_reg;
`else
    assign inst_timeout_o  = 1'b0;
`endif
    assign stall_req_o     = (state_reg != ST_IDLE) || need;

endmodule

// File: tb/tb_inst_fetch_resp.sv
// ----------------------------------------------------------------------------
// tb_inst_fetch_resp
// Directed bench for inst_fetch_resp. Inputs change on the falling edge and
// outputs are sampled there too. Expected fetch results are queued when a
// fetch is launched and popped when the DUT reports the instruction.
// ----------------------------------------------------------------------------
module tb_inst_fetch_resp;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic [31:0] inst;
        logic        mis;
        logic        tmo;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        n_rst_i;
    logic        ce_i;
    logic [31:0] pc_i;
    logic        flush_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic [31:0] inst_o;
    logic        inst_valid_o;
    logic        inst_misalign_o;
    logic        inst_timeout_o;
    logic        stall_req_o;

    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];

    always #5 clk_i = ~clk_i;

    inst_fetch_resp dut (
        .clk_i           (clk_i),
        .n_rst_i         (n_rst_i),
        .ce_i            (ce_i),
        .pc_i            (pc_i),
        .flush_i         (flush_i),
        .mem_req_o       (mem_req_o),
        .mem_addr_o      (mem_addr_o),
        .mem_ack_i       (mem_ack_i),
        .mem_rdata_i     (mem_rdata_i),
        .inst_o          (inst_o),
        .inst_valid_o    (inst_valid_o),
        .inst_misalign_o (inst_misalign_o),
        .inst_timeout_o  (inst_timeout_o),
        .stall_req_o     (stall_req_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic push(input logic [31:0] inst, input logic mis, input logic tmo);
        exp_t e;
        e.inst = inst;
        e.mis  = mis;
        e.tmo  = tmo;
        sb.push_back(e);
    endtask

    // Pop the oldest expected result and compare it with what decode sees now.
    task automatic sb_check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL %s observed=result expected=empty_scoreboard", tag);
        end else begin
            e = sb.pop_front();
            $display("[TB] %s inst=%h valid=%0b mis=%0b tmo=%0b", tag, inst_o,
                     inst_valid_o, inst_misalign_o, inst_timeout_o);
            chk({tag, "_inst"},  inst_o,          e.inst);
            chk({tag, "_valid"}, inst_valid_o,    1'b1);
            chk({tag, "_mis"},   inst_misalign_o, e.mis);
            chk({tag, "_tmo"},   inst_timeout_o,  e.tmo);
        end
    endtask

    // Called at a falling edge with ce_i/pc_i already driven. Acts as the bus,
    // acking on the ack_cycle-th cycle that mem_req_o is seen, and returns the
    // number of cycles stall_req_o was high.
    task automatic run_fetch(input string tag, input logic [31:0] addr,
                             input logic [31:0] data, input int ack_cycle,
                             output int stalls);
        int reqc;
        stalls = 0;
        reqc   = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (stall_req_o) stalls++;
            else if (i > 0) break;
            if (mem_req_o) begin
                reqc++;
                chk({tag, "_addr"}, mem_addr_o, addr);
                if (reqc == ack_cycle) begin
                    mem_ack_i   = 1'b1;
                    mem_rdata_i = data;
                end
            end
            cyc();
            mem_ack_i   = 1'b0;
            mem_rdata_i = 32'hFFFF_FFFF;
        end
    endtask

    initial begin
        int stalls;
        int cnt;

        n_rst_i     = 1'b0;
        ce_i        = 1'b0;
        pc_i        = '0;
        flush_i     = 1'b0;
        mem_ack_i   = 1'b0;
        mem_rdata_i = 32'hFFFF_FFFF;
        repeat (3) cyc();

        // Reset state
        chk("rst_req",   mem_req_o,       1'b0);
        chk("rst_addr",  mem_addr_o,      32'h0);
        chk("rst_inst",  inst_o,          NOP);
        chk("rst_valid", inst_valid_o,    1'b0);
        chk("rst_mis",   inst_misalign_o, 1'b0);
        chk("rst_tmo",   inst_timeout_o,  1'b0);
        chk("rst_stall", stall_req_o,     1'b0);
        n_rst_i = 1'b1;
        cyc();

        // Basic fetch, ack on third request cycle
        ce_i = 1'b1;
        pc_i = 32'h8000_0000;
        push(32'h0050_0093, 1'b0, 1'b0);
        run_fetch("basic", 32'h8000_0000, 32'h0050_0093, 3, stalls);
        chk("basic_stalls", stalls, 4);
        chk("basic_req", mem_req_o, 1'b0);
        sb_check("basic");

        // Same pc held: no refetch, outputs unchanged
        for (int i = 0; i < 3; i++) begin
            chk("hold_req",   mem_req_o,    1'b0);
            chk("hold_inst",  inst_o,       32'h0050_0093);
            chk("hold_valid", inst_valid_o, 1'b1);
            chk("hold_stall", stall_req_o,  1'b0);
            cyc();
        end

        // Misaligned pc answered locally in one cycle
        pc_i = 32'h8000_0002;
        #1;
        chk("mis_stall_pre", stall_req_o, 1'b1);
        push(NOP, 1'b1, 1'b0);
        cyc();
        chk("mis_req", mem_req_o, 1'b0);
        chk("mis_stall_post", stall_req_o, 1'b0);
        sb_check("misalign");

        // Flush one cycle after request, ack two cycles later -> DRAIN
        pc_i = 32'h8000_0010;
        cyc();
        chk("drain_req0", mem_req_o, 1'b1);
        chk("drain_addr0", mem_addr_o, 32'h8000_0010);
        flush_i = 1'b1;
        cyc();
        flush_i = 1'b0;
        chk("drain_valid", inst_valid_o, 1'b0);
        chk("drain_req1", mem_req_o, 1'b1);
        #1;
        chk("drain_stall", stall_req_o, 1'b1);
        cyc();
        chk("drain_req2", mem_req_o, 1'b1);
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'hDEAD_BEEF;
        cyc();
        mem_ack_i   = 1'b0;
        mem_rdata_i = 32'hFFFF_FFFF;
        chk("drain_req_end", mem_req_o, 1'b0);
        chk("drain_valid_end", inst_valid_o, 1'b0);
        chk("drain_inst_end", inst_o, NOP);
        pc_i = 32'h8000_0020;
        push(32'h00A0_0113, 1'b0, 1'b0);
        run_fetch("after_drain", 32'h8000_0020, 32'h00A0_0113, 1, stalls);
        chk("after_drain_stalls", stalls, 2);
        sb_check("after_drain");

        // Flush coincident with ack
        pc_i = 32'h8000_0030;
        cyc();
        chk("fa_req", mem_req_o, 1'b1);
        flush_i     = 1'b1;
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'hCAFE_F00D;
        cyc();
        flush_i     = 1'b0;
        mem_ack_i   = 1'b0;
        mem_rdata_i = 32'hFFFF_FFFF;
        chk("fa_req_end", mem_req_o, 1'b0);
        chk("fa_valid", inst_valid_o, 1'b0);
        chk("fa_inst", inst_o, 32'h00A0_0113);
        #1;
        chk("fa_stall_refetch", stall_req_o, 1'b1);
        ce_i = 1'b0;
        #1;
        chk("fa_idle_stall", stall_req_o, 1'b0);

        // ce_i low in IDLE: nothing happens
        for (int i = 0; i < 2; i++) begin
            cyc();
            chk("ce0_req",  mem_req_o, 1'b0);
            chk("ce0_inst", inst_o,    32'h00A0_0113);
        end

        // ce_i dropped during BUSY does not cancel the transfer
        ce_i = 1'b1;
        pc_i = 32'h8000_0040;
        cyc();
        ce_i = 1'b0;
        cyc();
        cyc();
        chk("ceb_req",  mem_req_o,  1'b1);
        chk("ceb_addr", mem_addr_o, 32'h8000_0040);
        chk("ceb_stall", stall_req_o, 1'b1);
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'h0020_8233;
        push(32'h0020_8233, 1'b0, 1'b0);
        cyc();
        mem_ack_i   = 1'b0;
        mem_rdata_i = 32'hFFFF_FFFF;
        sb_check("ce_low_busy");

        // Flush in IDLE clears validity and forces a refetch of the same pc
        ce_i = 1'b1;
        #1;
        chk("fi_stall_pre", stall_req_o, 1'b0);
        flush_i = 1'b1;
        cyc();
        flush_i = 1'b0;
        chk("fi_valid", inst_valid_o, 1'b0);
        push(32'h0030_8293, 1'b0, 1'b0);
        run_fetch("refetch", 32'h8000_0040, 32'h0030_8293, 2, stalls);
        chk("refetch_stalls", stalls, 3);
        sb_check("refetch");

        // No ack for a long time
        pc_i = 32'h8000_0100;
        cyc();
        cnt = 0;
        for (int i = 0; i < 300; i++) begin
            if (!mem_req_o) break;
            cnt++;
            cyc();
        end
`ifdef INST_FETCH_TIMEOUT_EN
        chk("tmo_cycles", cnt, 256);
        chk("tmo_req", mem_req_o, 1'b0);
        push(NOP, 1'b0, 1'b1);
        sb_check("timeout");
        pc_i = 32'h8000_0104;
        push(32'h1111_1111, 1'b0, 1'b0);
        run_fetch("post_tmo", 32'h8000_0104, 32'h1111_1111, 1, stalls);
        chk("post_tmo_stalls", stalls, 2);
        sb_check("post_timeout");
`else
        chk("notmo_cycles", cnt, 300);
        chk("notmo_req", mem_req_o, 1'b1);
        chk("notmo_tmo", inst_timeout_o, 1'b0);
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'h1111_1111;
        push(32'h1111_1111, 1'b0, 1'b0);
        cyc();
        mem_ack_i   = 1'b0;
        mem_rdata_i = 32'hFFFF_FFFF;
        sb_check("late_ack");
`endif

        // Reset during BUSY drops the request at that edge
        pc_i = 32'h8000_0200;
        cyc();
        chk("rb_req", mem_req_o, 1'b1);
        n_rst_i = 1'b0;
        ce_i    = 1'b0;
        cyc();
        chk("rb_req_rst", mem_req_o,    1'b0);
        chk("rb_addr",    mem_addr_o,   32'h0);
        chk("rb_inst",    inst_o,       NOP);
        chk("rb_valid",   inst_valid_o, 1'b0);
        chk("rb_stall",   stall_req_o,  1'b0);
        n_rst_i = 1'b1;
        cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
